control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPW, default 5, opcode width taken from IR[31:32-OPW].
REQ-002 Parameter WAITMAX, default 15, memory-wait timeout in cycles; 0 disables the timeout.
REQ-003 Parameter HALT_OP, default 5'b11011, opcode that halts permanently.
REQ-004 Clock  input  1  rising-edge clock.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 IR  input  32  instruction register contents, valid from the cycle after step T2.
REQ-007 Mem_Ready  input  1  memory handshake; high means the current Read or Write completes this cycle.
REQ-008 Con_FF  input  1  branch condition flip-flop.
REQ-009 Stop  input  1  halt request.
REQ-010 Ctl  output  23  datapath strobe vector: [0]PCout [1]PCin [2]IncPC [3]MARin [4]MDRin [5]MDRout [6]IRin [7]Read [8]Write [9]Gra [10]Grb [11]Grc [12]Rout [13]Rin [14]BAout [15]Yin [16]Zin [17]Zlowout [18]Zhighout [19]HIin [20]LOin [21]CONin [22]Cout.
REQ-011 Alu_Op  output  OPW  ALU operation code.
REQ-012 Step  output  3  current T-step, 0-7.
REQ-013 Run  output  1  high while sequencing.
REQ-014 Fault  output  1  sticky memory-timeout flag.

Function
REQ-015 The FSM SHALL have the states RESET, T0-T7, HALT, and SHALL be Moore-encoded: Ctl, Alu_Op and Step are functions of state only, except the Con_FF term in REQ-023.
REQ-016 Any Ctl bit not listed for the current step SHALL be 0.
REQ-017 Fetch SHALL proceed as follows:
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
REQ-018 T1 SHALL hold, with Ctl unchanged but PCin deasserted after its first cycle, until Mem_Ready=1; it advances on the edge where Mem_Ready=1 is sampled.
REQ-019 Decode SHALL occur at the end of T2 using the opcode, as specified in REQ-020 to REQ-024.
REQ-020 ALU ops, opcodes 00011-01010, SHALL sequence as follows, then return to T0:
- T3: Grb, Rout, Yin.
- T4: Grc, Rout, Zin, with Alu_Op=opcode.
- T5: Zlowout, Gra, Rin.
REQ-021 MUL/DIV, opcodes 01111/10000, SHALL sequence as follows, then return to T0:
- T3: Gra, Rout, Yin.
- T4: Grb, Rout, Zin, with Alu_Op=opcode.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
REQ-022 LD (00000) and ST (00010) SHALL sequence as follows, then return to T0:
- T3: Grb, BAout, Yin.
- T4: Cout, Zin, with Alu_Op=00011.
- T5: Zlowout, MARin.
- LD T6: Read, MDRin, memory-wait per REQ-018.
- LD T7: MDRout, Gra, Rin.
- ST T6: Gra, Rout, MDRin.
- ST T7: Write, memory-wait.
REQ-023 BR (10011) SHALL sequence as follows, then return to T0:
- T3: Gra, Rout, CONin.
- T4: PCout, Yin.
- T5: Cout, Zin, with Alu_Op=00011.
- T6: Zlowout and PCin only if Con_FF=1; otherwise Ctl=0.
REQ-024 HALT_OP SHALL go to HALT and latch a permanent-halt flag; any other opcode SHALL return to T0 with no T3 cycle.
REQ-025 Alu_Op SHALL be 0 outside the steps that define it.
REQ-026 Whenever the FSM would enter T0 and Stop=1, it SHALL enter HALT instead.
REQ-027 HALT SHALL drive Run=0 and Ctl=0; it exits to T0 when Stop=0, the permanent-halt flag is 0 and Fault=0.
REQ-028 A wait counter SHALL count consecutive Mem_Ready=0 cycles in any wait step and clear on step exit.
REQ-029 When WAITMAX≠0 and the wait counter reaches WAITMAX, Fault SHALL be set to 1 and the FSM SHALL go to HALT with no completing strobe.
REQ-030 Step SHALL equal the T index, and 0 in RESET and HALT.

Reset
REQ-031 Reset=1 SHALL immediately force state RESET, Ctl=0, Alu_Op=0, Step=0, Run=0, Fault=0, wait counter=0 and permanent-halt flag=0.
REQ-032 Reset asserted mid-instruction, including during a Write wait, SHALL abort the instruction with no further strobe.
REQ-033 On the first edge after Reset deasserts, the FSM SHALL enter T0 with Run=1, unless Stop=1, in which case it enters HALT.

Verification
REQ-034 The bench SHALL cover: IR opcode 00011, Mem_Ready=1 -> steps 0,1,2,3,4,5,0; Alu_Op=00011 only in T4; Gra+Rin in T5.
REQ-035 The bench SHALL cover: LD with Mem_Ready low 3 cycles in T6 -> T6 lasts 4 cycles with Read+MDRin held; T7 asserts MDRout+Gra+Rin once.
REQ-036 The bench SHALL cover: BR with Con_FF=0, then Con_FF=1 -> T6 Ctl=0, then T6 Ctl has Zlowout+PCin.
REQ-037 The bench SHALL cover: WAITMAX=4, Mem_Ready stuck low in T1 -> Fault=1 after 4 wait cycles, HALT, Run=0; Stop toggling does not exit; Reset clears.
REQ-038 The bench SHALL cover: Stop=1 during a MUL -> T6 completes with HIin, then HALT; Stop=0 -> T0 next cycle.
REQ-039 The bench SHALL cover: Reset pulsed during ST T7 wait -> Write drops in the same cycle, Step=0; T0 on the first edge after release.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: Moore T-step sequencer driving datapath strobes for fetch/decode/execute.
// Ports: clk_i/rst_i clock and async active-high reset; ir_i instruction register;
// mem_ready_i memory handshake; con_ff_i branch condition; stop_i halt request;
// ctl_o 23-bit strobe vector; alu_op_o ALU code; step_o T index; run_o sequencing; fault_o sticky timeout.
module control_sequencer #(
  parameter int OPW = 5,
  parameter int WAITMAX = 15,
  parameter logic [OPW-1:0] HALT_OP = 5'b11011
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [31:0]    ir_i,
  input  logic           mem_ready_i,
  input  logic           con_ff_i,
  input  logic           stop_i,
  output logic [22:0]    ctl_o,
  output logic [OPW-1:0] alu_op_o,
  output logic [2:0]     step_o,
  output logic           run_o,
  output logic           fault_o
);
  localparam int PCOUT = 0, PCIN = 1, INCPC = 2, MARIN = 3, MDRIN = 4, MDROUT = 5, IRIN = 6;
  localparam int READ = 7, WRITE = 8, GRA = 9, GRB = 10, GRC = 11, ROUT = 12, RIN = 13;
  localparam int BAOUT = 14, YIN = 15, ZIN = 16, ZLOWOUT = 17, ZHIGHOUT = 18, HIIN = 19;
  localparam int LOIN = 20, CONIN = 21, COUT = 22;
  localparam int CW = $clog2(WAITMAX + 2);
  // T0..T7 encode their own step index so step_o is a slice of the state
  typedef enum logic [3:0] {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_RESET, S_HALT} state_t;
  state_t state_q, state_d, nxt_t0;
  logic [OPW-1:0] op_q, op_d, opc;
  logic [CW-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic fault_q, fault_d, hlt_q, hlt_d;
  logic is_alu, is_md, is_ld, is_st, is_br, wait_st, timeout;
  function automatic logic known(input logic [OPW-1:0] o);
    return (o >= OPW'(3) && o <= OPW'(10)) || o == OPW'(15) || o == OPW'(16) ||
           o == OPW'(0) || o == OPW'(2) || o == OPW'(19);
  endfunction
  assign opc = ir_i[31 -: OPW];
  assign is_alu = op_q >= OPW'(3) && op_q <= OPW'(10);
  assign is_md = op_q == OPW'(15) || op_q == OPW'(16);
  assign is_ld = op_q == OPW'(0);
  assign is_st = op_q == OPW'(2);
  assign is_br = op_q == OPW'(19);
  assign nxt_t0 = stop_i ? S_HALT : S_T0;
  assign wait_st = state_q == S_T1 || (state_q == S_T6 && is_ld) || (state_q == S_T7 && is_st);
  // saturate so a disabled timeout never wraps back to a "first cycle" count
  assign wcnt_inc = (&wcnt_q) ? wcnt_q : wcnt_q + CW'(1);
  assign timeout = WAITMAX != 0 && wcnt_inc == CW'(WAITMAX);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RESET;
      op_q <= '0;
      wcnt_q <= '0;
      fault_q <= 1'b0;
      hlt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      wcnt_q <= wcnt_d;
      fault_q <= fault_d;
      hlt_q <= hlt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    wcnt_d = '0;
    fault_d = fault_q;
    hlt_d = hlt_q;
    case (state_q)
      S_RESET: state_d = nxt_t0;
      S_T0: state_d = S_T1;
      S_T1: state_d = mem_ready_i ? S_T2 : S_T1;
      S_T2: begin
        op_d = opc;
        hlt_d = hlt_q | (opc == HALT_OP);
        state_d = opc == HALT_OP ? S_HALT : known(opc) ? S_T3 : nxt_t0;
      end
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: state_d = is_alu ? nxt_t0 : S_T6;
      S_T6: state_d = is_ld ? (mem_ready_i ? S_T7 : S_T6) : is_st ? S_T7 : nxt_t0;
      S_T7: state_d = is_st ? (mem_ready_i ? nxt_t0 : S_T7) : nxt_t0;
      S_HALT: state_d = (!stop_i && !hlt_q && !fault_q) ? S_T0 : S_HALT;
      default: state_d = S_RESET;
    endcase
    if (wait_st && !mem_ready_i) begin
      wcnt_d = wcnt_inc;
      if (timeout) begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    end
  end
  always_comb begin
    ctl_o = '0;
    alu_op_o = '0;
    case (state_q)
      S_T0: begin ctl_o[PCOUT] = 1'b1; ctl_o[MARIN] = 1'b1; ctl_o[INCPC] = 1'b1; ctl_o[ZIN] = 1'b1; end
      S_T1: begin
        ctl_o[ZLOWOUT] = 1'b1; ctl_o[READ] = 1'b1; ctl_o[MDRIN] = 1'b1;
        // PC is loaded only once even if memory stalls
        ctl_o[PCIN] = wcnt_q == '0;
      end
      S_T2: begin ctl_o[MDROUT] = 1'b1; ctl_o[IRIN] = 1'b1; end
      S_T3: begin
        ctl_o[GRA] = is_md || is_br; ctl_o[GRB] = is_alu || is_ld || is_st;
        ctl_o[ROUT] = is_alu || is_md || is_br; ctl_o[BAOUT] = is_ld || is_st;
        ctl_o[YIN] = !is_br; ctl_o[CONIN] = is_br;
      end
      S_T4: begin
        ctl_o[GRB] = is_md; ctl_o[GRC] = is_alu; ctl_o[ROUT] = is_alu || is_md;
        ctl_o[ZIN] = !is_br; ctl_o[COUT] = is_ld || is_st;
        ctl_o[PCOUT] = is_br; ctl_o[YIN] = is_br;
        alu_op_o = (is_alu || is_md) ? op_q : (is_ld || is_st) ? OPW'(3) : '0;
      end
      S_T5: begin
        ctl_o[ZLOWOUT] = !is_br; ctl_o[GRA] = is_alu; ctl_o[RIN] = is_alu;
        ctl_o[LOIN] = is_md; ctl_o[MARIN] = is_ld || is_st;
        ctl_o[COUT] = is_br; ctl_o[ZIN] = is_br;
        alu_op_o = is_br ? OPW'(3) : '0;
      end
      S_T6: begin
        ctl_o[ZHIGHOUT] = is_md; ctl_o[HIIN] = is_md;
        ctl_o[READ] = is_ld; ctl_o[MDRIN] = is_ld || is_st;
        ctl_o[GRA] = is_st; ctl_o[ROUT] = is_st;
        ctl_o[ZLOWOUT] = is_br && con_ff_i; ctl_o[PCIN] = is_br && con_ff_i;
      end
      S_T7: begin
        ctl_o[MDROUT] = is_ld; ctl_o[GRA] = is_ld; ctl_o[RIN] = is_ld;
        ctl_o[WRITE] = is_st;
      end
      default: ctl_o = '0;
    endcase
  end
  assign step_o = state_q[3] ? 3'd0 : state_q[2:0];
  assign run_o = !(state_q == S_RESET || state_q == S_HALT);
  assign fault_o = fault_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench for control_sequencer with hand-computed strobe expectations.
module tb_control_sequencer;
  logic clk = 1'b0, rst = 1'b1, mem = 1'b1, con = 1'b0, stop = 1'b0;
  logic [31:0] ir = '0;
  logic [22:0] ctl;
  logic [4:0] alu_op;
  logic [2:0] step;
  logic run, fault;
  int checks = 0, errors = 0;
  localparam int T0M = (1<<0)|(1<<3)|(1<<2)|(1<<16);
  localparam int T1M = (1<<17)|(1<<7)|(1<<4);
  localparam int T2M = (1<<5)|(1<<6);
  control_sequencer #(.OPW(5), .WAITMAX(4), .HALT_OP(5'b11011)) dut (
    .clk_i(clk), .rst_i(rst), .ir_i(ir), .mem_ready_i(mem), .con_ff_i(con), .stop_i(stop),
    .ctl_o(ctl), .alu_op_o(alu_op), .step_o(step), .run_o(run), .fault_o(fault)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_op(input logic [4:0] op);
    ir = {op, 27'd0};
  endtask
  initial begin
    tick(); tick();
    chk("rst_ctl", 32'(ctl), 0); chk("rst_step", 32'(step), 0);
    chk("rst_run", 32'(run), 0); chk("rst_fault", 32'(fault), 0); chk("rst_alu", 32'(alu_op), 0);
    set_op(5'b00011);
    rst = 1'b0;
    tick(); chk("add_t0_step", 32'(step), 0); chk("add_t0_run", 32'(run), 1); chk("add_t0_ctl", 32'(ctl), T0M);
    tick(); chk("add_t1_step", 32'(step), 1); chk("add_t1_ctl", 32'(ctl), T1M | (1<<1));
    tick(); chk("add_t2_ctl", 32'(ctl), T2M);
    tick(); chk("add_t3_step", 32'(step), 3); chk("add_t3_ctl", 32'(ctl), (1<<10)|(1<<12)|(1<<15));
    chk("add_t3_alu", 32'(alu_op), 0);
    tick(); chk("add_t4_step", 32'(step), 4); chk("add_t4_alu", 32'(alu_op), 3);
    chk("add_t4_ctl", 32'(ctl), (1<<11)|(1<<12)|(1<<16));
    tick(); chk("add_t5_step", 32'(step), 5); chk("add_t5_ctl", 32'(ctl), (1<<17)|(1<<9)|(1<<13));
    chk("add_t5_alu", 32'(alu_op), 0);
    tick(); chk("add_end_step", 32'(step), 0); chk("add_end_ctl", 32'(ctl), T0M);
    set_op(5'b00000);
    tick(); tick();
    tick(); chk("ld_t3_ctl", 32'(ctl), (1<<10)|(1<<14)|(1<<15));
    tick(); chk("ld_t4_ctl", 32'(ctl), (1<<22)|(1<<16)); chk("ld_t4_alu", 32'(alu_op), 3);
    tick(); chk("ld_t5_ctl", 32'(ctl), (1<<17)|(1<<3));
    mem = 1'b0;
    tick(); chk("ld_t6a_step", 32'(step), 6); chk("ld_t6a_ctl", 32'(ctl), (1<<7)|(1<<4));
    tick(); chk("ld_t6b_step", 32'(step), 6);
    tick(); chk("ld_t6c_step", 32'(step), 6);
    tick(); chk("ld_t6d_step", 32'(step), 6); chk("ld_t6d_ctl", 32'(ctl), (1<<7)|(1<<4));
    mem = 1'b1;
    tick(); chk("ld_t7_step", 32'(step), 7); chk("ld_t7_ctl", 32'(ctl), (1<<5)|(1<<9)|(1<<13));
    tick(); chk("ld_end_step", 32'(step), 0); chk("ld_end_ctl", 32'(ctl), T0M);
    set_op(5'b10011);
    con = 1'b0;
    tick(); tick();
    tick(); chk("br_t3_ctl", 32'(ctl), (1<<9)|(1<<12)|(1<<21));
    tick(); chk("br_t4_ctl", 32'(ctl), (1<<0)|(1<<15)); chk("br_t4_alu", 32'(alu_op), 0);
    tick(); chk("br_t5_ctl", 32'(ctl), (1<<22)|(1<<16)); chk("br_t5_alu", 32'(alu_op), 3);
    tick(); chk("br0_t6_step", 32'(step), 6); chk("br0_t6_ctl", 32'(ctl), 0);
    tick(); chk("br0_end_step", 32'(step), 0);
    con = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    tick(); chk("br1_t6_step", 32'(step), 6); chk("br1_t6_ctl", 32'(ctl), (1<<17)|(1<<1));
    tick(); chk("br1_end_step", 32'(step), 0);
    con = 1'b0;
    set_op(5'b01111);
    tick(); tick();
    tick(); chk("mul_t3_ctl", 32'(ctl), (1<<9)|(1<<12)|(1<<15));
    tick(); chk("mul_t4_ctl", 32'(ctl), (1<<10)|(1<<12)|(1<<16)); chk("mul_t4_alu", 32'(alu_op), 5'b01111);
    tick(); chk("mul_t5_ctl", 32'(ctl), (1<<17)|(1<<20));
    stop = 1'b1;
    tick(); chk("mul_t6_step", 32'(step), 6); chk("mul_t6_ctl", 32'(ctl), (1<<18)|(1<<19));
    tick(); chk("mul_halt_run", 32'(run), 0); chk("mul_halt_step", 32'(step), 0); chk("mul_halt_ctl", 32'(ctl), 0);
    tick(); chk("mul_halt_hold", 32'(run), 0);
    stop = 1'b0;
    tick(); chk("resume_run", 32'(run), 1); chk("resume_ctl", 32'(ctl), T0M);
    set_op(5'b00010);
    tick(); tick(); tick(); tick(); tick();
    tick(); chk("st_t6_ctl", 32'(ctl), (1<<9)|(1<<12)|(1<<4));
    mem = 1'b0;
    tick(); chk("st_t7_step", 32'(step), 7); chk("st_t7_ctl", 32'(ctl), 1<<8);
    tick(); chk("st_wait_ctl", 32'(ctl), 1<<8);
    rst = 1'b1;
    #1; chk("st_rst_ctl", 32'(ctl), 0); chk("st_rst_step", 32'(step), 0); chk("st_rst_run", 32'(run), 0);
    tick();
    mem = 1'b1;
    rst = 1'b0;
    tick(); chk("st_rel_step", 32'(step), 0); chk("st_rel_run", 32'(run), 1); chk("st_rel_ctl", 32'(ctl), T0M);
    mem = 1'b0;
    tick(); chk("to_t1_ctl", 32'(ctl), T1M | (1<<1));
    tick(); chk("to_t1_nopc", 32'(ctl), T1M);
    tick(); tick(); chk("to_pre_fault", 32'(fault), 0); chk("to_pre_step", 32'(step), 1);
    tick(); chk("to_fault", 32'(fault), 1); chk("to_run", 32'(run), 0); chk("to_ctl", 32'(ctl), 0);
    stop = 1'b1; tick();
    stop = 1'b0; tick();
    mem = 1'b1; tick();
    chk("to_stuck_run", 32'(run), 0); chk("to_stuck_fault", 32'(fault), 1);
    rst = 1'b1;
    #1; chk("to_rst_fault", 32'(fault), 0);
    tick();
    set_op(5'b00001);
    rst = 1'b0;
    tick(); chk("nop_t0", 32'(step), 0);
    tick(); tick();
    tick(); chk("nop_back_step", 32'(step), 0); chk("nop_back_ctl", 32'(ctl), T0M);
    set_op(5'b11011);
    tick(); tick();
    tick(); chk("hlt_run", 32'(run), 0);
    tick(); tick(); chk("hlt_hold_run", 32'(run), 0); chk("hlt_hold_ctl", 32'(ctl), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
